// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             s_bit;
  logic             c_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    s_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    c_bit   = (opa_q[0] & opb_q[0]) |
              (opa_q[0] & carry_q) |
              (opb_q[0] & carry_q);
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = c_bit;
        psum_d  = (psum_q >> 1) |
                  (WIDTH'(s_bit) << (WIDTH - 1));
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = psum_d;
          cout_d  = c_bit;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB slice here
          ovf_d   = carry_q ^ c_bit;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder;

  typedef struct {
    logic [8:0] val;
    logic       ovf;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  bit         rst_seen = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  exp_t       q8[$];
  exp_t       q1[$];
  exp_t       e8, e1;
  logic [8:0] held8 = '0;
  logic       hovf8 = 1'b0;
  logic [1:0] held1 = '0;
  int         blen8 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  serial_adder #(.WIDTH(8)) u8 (
    .clk  (clk),
    .reset(rst),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk  (clk),
    .reset(rst),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf1)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cyc=%0d",
               nm, act, req, cyc);
    end
  endtask

  function automatic logic ovf_of(int w, longint a, longint b, longint c);
    longint sa, sb, s;
    sa = (((a >> (w - 1)) & 1) != 0) ? a - (longint'(1) << w) : a;
    sb = (((b >> (w - 1)) & 1) != 0) ? b - (longint'(1) << w) : b;
    s  = sa + sb + c;
    return (s > (longint'(1) << (w - 1)) - 1) || (s < -(longint'(1) << (w - 1)));
  endfunction

  function automatic exp_t mk8(logic [7:0] a, logic [7:0] b, logic c, int due);
    exp_t e;
    e.val = 9'(int'(a) + int'(b) + int'(c));
    e.ovf = ovf_of(8, longint'(a), longint'(b), longint'(c));
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset8_busy", 64'(busy8), 64'(0));
      chk("reset8_done", 64'(done8), 64'(0));
      chk("reset8_sum", 64'({cout8, sum8}), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset8_ovf", 64'(ovf8), 64'(0));
`endif
      q8.delete();
      held8 = '0;
      hovf8 = 1'b0;
      blen8 = 0;
    end else begin
      if (busy8 === 1'b1) begin
        blen8++;
      end else if (blen8 != 0) begin
        chk("busy8_len", 64'(blen8), 64'(8));
        blen8 = 0;
      end
      if (done8 === 1'b1) begin
        if (q8.size() == 0) begin
          chk("spurious_done8", 64'(1), 64'(0));
        end else begin
          e8 = q8.pop_front();
          chk("latency8", 64'(cyc), 64'(e8.due));
          held8 = e8.val;
          hovf8 = e8.ovf;
        end
      end
      chk("result8", 64'({cout8, sum8}), 64'(held8));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf8", 64'(ovf8), 64'(hovf8));
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset1", 64'({busy1, done1, cout1, sum1}), 64'(0));
      q1.delete();
      held1 = '0;
    end else begin
      if (done1 === 1'b1) begin
        if (q1.size() == 0) begin
          chk("spurious_done1", 64'(1), 64'(0));
        end else begin
          e1 = q1.pop_front();
          chk("latency1", 64'(cyc), 64'(e1.due));
          held1 = e1.val[1:0];
          chk("busy1_in_done", 64'(busy1), 64'(0));
        end
      end
      chk("result1", 64'({cout1, sum1}), 64'(held1));
    end
  end

  // Entered and left on a negedge; leaves the DUT in its DONE cycle.
  task automatic issue8(logic [7:0] a, logic [7:0] b, logic c);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    cin8 = c;
    q8.push_back(mk8(a, b, c, cyc + 9));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cin8 = 1'($urandom);
    repeat (8) @(negedge clk);
  endtask

  task automatic issue1(logic a, logic b, logic c);
    exp_t e;
    start1 = 1'b1;
    a1 = a;
    b1 = b;
    cin1 = c;
    e.val = 9'(int'(a) + int'(b) + int'(c));
    e.ovf = 1'b0;
    e.due = cyc + 2;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'($urandom);
    b1 = 1'($urandom);
    cin1 = 1'($urandom);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue8(8'h00, 8'h00, 1'b0);
    @(negedge clk);
    issue8(8'hFF, 8'h01, 1'b0);
    issue8(8'h7F, 8'h01, 1'b0);
    @(negedge clk);

    // start during RUN must be ignored
    start8 = 1'b1;
    a8 = 8'h3C;
    b8 = 8'h0F;
    cin8 = 1'b1;
    q8.push_back(mk8(8'h3C, 8'h0F, 1'b1, cyc + 9));
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    repeat (3) @(negedge clk);

    // reset in the middle of RUN aborts the add
    start8 = 1'b1;
    a8 = 8'hAA;
    b8 = 8'h55;
    cin8 = 1'b0;
    q8.push_back(mk8(8'hAA, 8'h55, 1'b0, cyc + 9));
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // start held high: DONE goes straight back to RUN
    start8 = 1'b1;
    a8 = 8'h10;
    b8 = 8'h20;
    cin8 = 1'b0;
    q8.push_back(mk8(8'h10, 8'h20, 1'b0, cyc + 9));
    repeat (9) @(negedge clk);
    a8 = 8'h01;
    b8 = 8'h02;
    q8.push_back(mk8(8'h01, 8'h02, 1'b0, cyc + 9));
    @(negedge clk);
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      issue8(ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      issue1(1'(i >> 2), 1'(i >> 1), 1'(i));
      if (i % 2 == 1) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the combinational half/full adder cells.
- Adds two WIDTH-bit operands plus a carry-in bit-serially: one full-adder slice and a carry flip-flop, one bit per clock, LSB first.
- Start/busy/done handshake.
- Used where area matters more than latency, e.g. in the cw datapath exercises and as a reusable arithmetic unit under a sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE state.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  registered result; holds the last completed value.
- cout  output  1  registered carry-out of the last completed addition.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

Behaviour:
- States:
  - IDLE, RUN, DONE.
  - Bit counter: clog2(WIDTH+1) bits.
  - Internal: operand shift registers opA and opB, carry register, partial-sum shift register.
- Reset (reset=1 at an edge, any state):
  - State -> IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Counter, carry and internal registers cleared.
  - Overrides start on the same edge.
  - Reset during RUN aborts the operation; no done pulse; sum/cout read 0.
- IDLE:
  - start=1 at edge E0: latch a->opA, b->opB, cin->carry; counter=0; state->RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), at each edge k=1..WIDTH:
  - s = opA[0]^opB[0]^carry.
  - carry <= majority(opA[0], opB[0], carry).
  - s shifted into the partial-sum MSB; opA and opB shifted right.
  - Counter increments.
- Final RUN edge (edge WIDTH):
  - Full partial sum copied to sum; final carry copied to cout.
  - State -> DONE.
- start while in RUN is ignored and not queued.
- Latency: start sampled at E0 -> done=1 during the cycle following edge E0+WIDTH.
  - busy=1 for exactly WIDTH cycles.
  - Total start-to-done latency: WIDTH+1 cycles from the start edge.
- DONE (done=1, busy=0, one cycle):
  - start=1: accept a new operation exactly as from IDLE, giving back-to-back throughput of one result per WIDTH+1 cycles.
  - Otherwise -> IDLE.
- sum and cout:
  - Change only on the final RUN edge or on reset.
  - Stable through DONE, IDLE and the whole of the next RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); operands treated as unsigned.
- WIDTH=1 boundary: single RUN cycle; behaves as a registered full adder.
- Operand inputs may change freely after the accepting edge without affecting the result.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Port ovf exists.
  - Registered on the final RUN edge as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Holds like sum; reset to 0.
- Not defined:
  - No ovf port and no associated logic.
  - All other behaviour identical.

Test Plan:
- WIDTH=8; a=0x00, b=0x00, cin=0, start pulse -> busy high 8 cycles; done pulse 9 cycles after start edge; sum=0x00, cout=0.
- WIDTH=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (ovf=0). Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0 (ovf=1).
- WIDTH=8; a=0x3C, b=0x0F, cin=1 accepted. At RUN cycle 3: start with a=0xFF, b=0xFF -> ignored; result sum=0x4C, cout=0, exactly one done pulse.
- WIDTH=8; a=0xAA, b=0x55 accepted. reset=1 at RUN cycle 4 -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse afterwards.
- WIDTH=8; start held high continuously with a=0x10, b=0x20 then a=0x01, b=0x02 -> done pulses every 9 cycles; sums 0x30 then 0x03; DONE->RUN transition without passing through IDLE.
- WIDTH=1 instance; all 8 (a,b,cin) combinations -> {cout,sum} equals a+b+cin; done asserted 2 cycles after each start edge.
